change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 23 ++
 rtl/change_dispenser_coin_select.sv | 21 ++
 rtl/change_dispenser.sv | 152 +++++++++++++++
 tb/tb_change_dispenser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions: condition codes, coin denominations and the
// change dispenser state encoding.
package change_dispenser_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] COND_INFO = 2'b00;
  localparam logic [1:0] COND_OUT  = 2'b01;
  localparam logic [1:0] COND_EXCH = 2'b10;

  localparam logic [DATA_W-1:0] COIN_50 = 32'd50;
  localparam logic [DATA_W-1:0] COIN_10 = 32'd10;
  localparam logic [DATA_W-1:0] COIN_5  = 32'd5;
  localparam logic [DATA_W-1:0] COIN_1  = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_FINISH   = 2'd2
  } state_e;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// coin_select: picks the largest denomination not exceeding the remaining
// change amount (0 when nothing remains).
//   remaining : amount still owed
//   coin_c    : largest coin (50/10/5/1) <= remaining, combinational
module coin_select
  import change_dispenser_pkg::*;
(
  input  logic [DATA_W-1:0] remaining,
  output logic [DATA_W-1:0] coin_c
);

  // Greedy denomination pick
  always_comb begin
    coin_c = '0;
    if (remaining >= COIN_50)      coin_c = COIN_50;
    else if (remaining >= COIN_10) coin_c = COIN_10;
    else if (remaining >= COIN_5)  coin_c = COIN_5;
    else if (remaining >= COIN_1)  coin_c = COIN_1;
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount into 50/10/5/1 coins handed to a
// coin hopper one at a time with a valid/ready handshake.
//   CLOCK, CLEAR     : clock, synchronous active-high reset
//   exchange_coin    : change amount requested by the vending FSM
//   condition        : vending FSM condition; rising into COND_EXCH triggers
//   hopper_ready     : hopper accepts the presented coin this cycle
//   coin_out/valid   : presented coin and its qualifier
//   busy/done/reject : request in progress / completion pulse / over-limit pulse
//   dispensed_total  : sum of accepted coins of the current or last request
// Optional (CHANGE_DENOM_COUNT_EN): n50/n10/n5/n1 per-denomination coin counts.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned MAX_CHANGE = 32'd200
) (
  input  logic              CLOCK,
  input  logic              CLEAR,
  input  logic [31:0]       exchange_coin,
  input  logic [1:0]        condition,
  input  logic              hopper_ready,
  output logic [31:0]       coin_out,
  output logic              coin_valid,
  output logic              busy,
  output logic              done,
  output logic              reject,
  output logic [31:0]       dispensed_total
`ifdef CHANGE_DENOM_COUNT_EN
  ,
  output logic [CNT_W-1:0]  n50,
  output logic [CNT_W-1:0]  n10,
  output logic [CNT_W-1:0]  n5,
  output logic [CNT_W-1:0]  n1
`endif
);

  localparam logic [DATA_W-1:0] MAX_W = DATA_W'(MAX_CHANGE);

  state_e            state_q, state_d;
  logic [1:0]        cond_q;
  logic [DATA_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] coin_sel_c;
  logic              trigger_c;
  logic              take_c;
  logic              accept_c;
  logic              reject_c;

  logic [DATA_W-1:0] coin_out_d;
  logic              coin_valid_d;
  logic              busy_d;
  logic              done_d;
  logic [DATA_W-1:0] total_d;

  assign trigger_c = (condition == COND_EXCH) && (cond_q != COND_EXCH);
  assign take_c    = (state_q == ST_DISPENSE) && coin_valid && hopper_ready;

  // Coin for the next cycle is chosen from the post-edge remainder so the
  // presented coin is available right after the triggering/accepting edge.
  coin_select u_coin_select (
    .remaining (remaining_d),
    .coin_c    (coin_sel_c)
  );

  // State register
  always_ff @(posedge CLOCK) begin
    if (CLEAR) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and remainder
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    accept_c    = 1'b0;
    reject_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          if (exchange_coin == '0) begin
            accept_c = 1'b1;
            state_d  = ST_FINISH;
          end else if (exchange_coin > MAX_W) begin
            reject_c = 1'b1;
          end else begin
            accept_c    = 1'b1;
            remaining_d = exchange_coin;
            state_d     = ST_DISPENSE;
          end
        end
      end
      ST_DISPENSE: begin
        if (take_c) begin
          remaining_d = remaining_q - coin_out;
          if (remaining_d == '0) state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    coin_valid_d = (state_d == ST_DISPENSE);
    coin_out_d   = coin_valid_d ? coin_sel_c : '0;
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_FINISH);
    total_d      = dispensed_total;
    if (accept_c)    total_d = '0;
    else if (take_c) total_d = dispensed_total + coin_out;
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      cond_q          <= COND_INFO;
      remaining_q     <= '0;
      coin_out        <= '0;
      coin_valid      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      reject          <= 1'b0;
      dispensed_total <= '0;
    end else begin
      cond_q          <= condition;
      remaining_q     <= remaining_d;
      coin_out        <= coin_out_d;
      coin_valid      <= coin_valid_d;
      busy            <= busy_d;
      done            <= done_d;
      reject          <= reject_c;
      dispensed_total <= total_d;
    end
  end

`ifdef CHANGE_DENOM_COUNT_EN
  // Per-denomination counts of accepted coins
  always_ff @(posedge CLOCK) begin
    if (CLEAR || accept_c) begin
      n50 <= '0;
      n10 <= '0;
      n5  <= '0;
      n1  <= '0;
    end else if (take_c) begin
      if (coin_out == COIN_50) n50 <= n50 + CNT_W'(1);
      if (coin_out == COIN_10) n10 <= n10 + CNT_W'(1);
      if (coin_out == COIN_5)  n5  <= n5  + CNT_W'(1);
      if (coin_out == COIN_1)  n1  <= n1  + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected coins and
// completion events; a negedge monitor pops and compares them.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  typedef enum int {EV_COIN, EV_DONE, EV_REJECT} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] value;
  } ev_t;

  logic        CLOCK = 1'b0;
  logic        CLEAR;
  logic [31:0] exchange_coin;
  logic [1:0]  condition;
  logic        hopper_ready;
  logic [31:0] coin_out;
  logic        coin_valid;
  logic        busy;
  logic        done;
  logic        reject;
  logic [31:0] dispensed_total;
`ifdef CHANGE_DENOM_COUNT_EN
  logic [7:0]  n50, n10, n5, n1;
`endif

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  valid_cycles = 0;
  int  coin10_cycles = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_val  = '0;

  change_dispenser #(.MAX_CHANGE(32'd200)) dut (
    .CLOCK           (CLOCK),
    .CLEAR           (CLEAR),
    .exchange_coin   (exchange_coin),
    .condition       (condition),
    .hopper_ready    (hopper_ready),
    .coin_out        (coin_out),
    .coin_valid      (coin_valid),
    .busy            (busy),
    .done            (done),
    .reject          (reject),
    .dispensed_total (dispensed_total)
`ifdef CHANGE_DENOM_COUNT_EN
    ,
    .n50             (n50),
    .n10             (n10),
    .n5              (n5),
    .n1              (n1)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input ev_kind_e kind, input string name, input logic [31:0] act);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event, value %0d (t=%0t)", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 32'(kind), 32'(e.kind));
      check(name, act, e.value);
    end
  endtask

  task automatic push(input ev_kind_e kind, input logic [31:0] value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  // Monitor: compares DUT events against the scoreboard, checks coin hold
  always @(negedge CLOCK) begin
    if (hold_pend) check("coin_hold", {coin_valid ? coin_out : 32'hFFFF_FFFF}, hold_val);
    if (coin_valid) valid_cycles++;
    if (coin_valid && coin_out == 32'd10) coin10_cycles++;
    if (coin_valid && hopper_ready && !CLEAR) pop_check(EV_COIN, "coin", coin_out);
    if (done) pop_check(EV_DONE, "done_total", dispensed_total);
    if (reject) pop_check(EV_REJECT, "reject", 32'd0);
    hold_pend = coin_valid && !hopper_ready && !CLEAR;
    hold_val  = coin_out;
  end

  // Presents a request: condition rises to exchange for one sampling edge
  task automatic issue(input logic [31:0] amt);
    exchange_coin = amt;
    condition     = COND_EXCH;
    @(posedge CLOCK) #1;
    condition = COND_INFO;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK);
      if (!busy && !done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, c0, busy_hi;
    CLEAR         = 1'b1;
    exchange_coin = '0;
    condition     = COND_INFO;
    hopper_ready  = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_coin_out", coin_out, 0);
    check("rst_coin_valid", 32'(coin_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_reject", 32'(reject), 0);
    check("rst_total", dispensed_total, 0);
    CLEAR = 1'b0;
    repeat (2) @(posedge CLOCK) #1;

    // 66 with hopper always ready: 50,10,5,1 back to back
    push(EV_COIN, 50); push(EV_COIN, 10); push(EV_COIN, 5); push(EV_COIN, 1);
    push(EV_DONE, 66);
    v0 = valid_cycles;
    issue(66);
    check("lat_valid", 32'(coin_valid), 1);
    check("lat_coin", coin_out, 50);
    check("lat_busy", 32'(busy), 1);
    wait_idle();
    check("r66_valid_cycles", 32'(valid_cycles - v0), 4);
    check("r66_total_kept", dispensed_total, 66);
    repeat (3) @(posedge CLOCK) #1;

    // 17 with hopper stalled 3 cycles on the 10
    push(EV_COIN, 10); push(EV_COIN, 5); push(EV_COIN, 1); push(EV_COIN, 1);
    push(EV_DONE, 17);
    c0 = coin10_cycles;
    hopper_ready = 1'b0;
    issue(17);
    repeat (3) @(posedge CLOCK) #1;
    hopper_ready = 1'b1;
    wait_idle();
    check("r17_ten_cycles", 32'(coin10_cycles - c0), 4);
    repeat (3) @(posedge CLOCK) #1;

    // zero amount: done only
    push(EV_DONE, 0);
    v0 = valid_cycles;
    issue(0);
    check("r0_busy", 32'(busy), 1);
    wait_idle();
    check("r0_no_coins", 32'(valid_cycles - v0), 0);
    repeat (3) @(posedge CLOCK) #1;

    // over the limit: reject, no coins, never busy
    push(EV_REJECT, 0);
    v0 = valid_cycles;
    busy_hi = 0;
    issue(250);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      if (busy) busy_hi++;
    end
    check("r250_busy_cycles", 32'(busy_hi), 0);
    check("r250_no_coins", 32'(valid_cycles - v0), 0);
    check("r250_total_kept", dispensed_total, 0);
    @(posedge CLOCK) #1;

    // condition held at exchange for 20 cycles: a single request
    push(EV_COIN, 5); push(EV_DONE, 5);
    v0 = valid_cycles;
    exchange_coin = 5;
    condition = COND_EXCH;
    repeat (20) @(posedge CLOCK) #1;
    condition = COND_INFO;
    wait_idle();
    check("hold_one_coin", 32'(valid_cycles - v0), 1);
    repeat (3) @(posedge CLOCK) #1;

    // CLEAR after the first 50 of a 100 request
    push(EV_COIN, 50);
    issue(100);
    @(posedge CLOCK) #1;
    check("clr_pre_coin", coin_out, 50);
    CLEAR = 1'b1;
    hopper_ready = 1'b0;
    @(posedge CLOCK) #1;
    CLEAR = 1'b0;
    hopper_ready = 1'b1;
    check("clr_coin_out", coin_out, 0);
    check("clr_coin_valid", 32'(coin_valid), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_done", 32'(done), 0);
    check("clr_reject", 32'(reject), 0);
    check("clr_total", dispensed_total, 0);
    v0 = valid_cycles;
    repeat (4) @(posedge CLOCK) #1;
    check("clr_stays_idle", 32'(valid_cycles - v0), 0);

`ifdef CHANGE_DENOM_COUNT_EN
    push(EV_COIN, 50); push(EV_COIN, 50); push(EV_COIN, 10); push(EV_COIN, 10);
    push(EV_COIN, 1); push(EV_COIN, 1); push(EV_DONE, 122);
    issue(122);
    wait_idle();
    check("n50", 32'(n50), 2);
    check("n10", 32'(n10), 2);
    check("n5", 32'(n5), 0);
    check("n1", 32'(n1), 2);
`endif

    repeat (3) @(posedge CLOCK) #1;
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
